// File: rtl/vram_write_arbiter.sv
// VRAM write arbiter: full-screen clear sweep and square brush stamping onto a
// single write port. Every output is registered, so each write shows up one cycle after its decision.
module vram_write_arbiter #(
  parameter int          DISPLAY_WIDTH  = 240,
  parameter int          DISPLAY_HEIGHT = 320,
  parameter int          BRUSH          = 3,
  parameter logic [15:0] CLEAR_COLOR    = 16'hFFFF,
  localparam int         ADDR_W         = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              touch_valid,
  input  logic [8:0]        touch_x,
  input  logic [8:0]        touch_y,
  input  logic [15:0]       pen_color,
  output logic              vram_wr_ena,
  output logic [ADDR_W-1:0] vram_wr_addr,
  output logic [15:0]       vram_wr_data,
  output logic              busy,
  output logic              clearing
);

  localparam int                NPIX      = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int                R         = (BRUSH - 1) / 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [3:0]        B_LAST    = 4'(BRUSH - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BRUSH} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_n, clr_addr;
  logic [8:0]        bx, by, bx_n, by_n, src_x, src_y;
  logic [15:0]       color, color_n, src_c;
  logic [3:0]        dx_i, dy_i, dx_n, dy_n, cdx, cdy;
  logic [8:0]        last_x, last_y, last_x_n, last_y_n;
  logic              last_valid, last_valid_n;
  logic              ena_n, busy_n, clearing_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       data_n;
  logic              touch_in, touch_new;
  int                px, py;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CLEAR;
      clr_cnt      <= '0;
      bx           <= '0;
      by           <= '0;
      color        <= '0;
      dx_i         <= '0;
      dy_i         <= '0;
      last_x       <= '0;
      last_y       <= '0;
      last_valid   <= 1'b0;
      vram_wr_ena  <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
      busy         <= 1'b1;
      clearing     <= 1'b1;
    end else begin
      state        <= state_n;
      clr_cnt      <= clr_cnt_n;
      bx           <= bx_n;
      by           <= by_n;
      color        <= color_n;
      dx_i         <= dx_n;
      dy_i         <= dy_n;
      last_x       <= last_x_n;
      last_y       <= last_y_n;
      last_valid   <= last_valid_n;
      vram_wr_ena  <= ena_n;
      vram_wr_addr <= addr_n;
      vram_wr_data <= data_n;
      busy         <= busy_n;
      clearing     <= clearing_n;
    end
  end

  always_comb begin
    state_n      = state;
    clr_cnt_n    = clr_cnt;
    bx_n         = bx;
    by_n         = by;
    color_n      = color;
    dx_n         = dx_i;
    dy_n         = dy_i;
    last_x_n     = last_x;
    last_y_n     = last_y;
    last_valid_n = last_valid;
    ena_n        = 1'b0;
    addr_n       = vram_wr_addr;
    data_n       = vram_wr_data;
    busy_n       = 1'b0;
    clearing_n   = 1'b0;
    src_x        = bx;
    src_y        = by;
    src_c        = color;
    cdx          = dx_i;
    cdy          = dy_i;
    px           = 0;
    py           = 0;
    clr_addr     = clr_cnt;

    touch_in  = touch_valid && (int'(touch_x) < DISPLAY_WIDTH) && (int'(touch_y) < DISPLAY_HEIGHT);
    touch_new = !(last_valid && (touch_x == last_x) && (touch_y == last_y));

    if (clear_req || state == S_CLEAR) begin
      // A clear request restarts the sweep, so address 0 is written on this very edge.
      clr_addr     = clear_req ? '0 : clr_cnt;
      ena_n        = 1'b1;
      addr_n       = clr_addr;
      data_n       = CLEAR_COLOR;
      busy_n       = 1'b1;
      clearing_n   = 1'b1;
      last_valid_n = 1'b0;
      dx_n         = '0;
      dy_n         = '0;
      if (clr_addr == LAST_ADDR) begin
        state_n   = S_IDLE;
        clr_cnt_n = '0;
      end else begin
        state_n   = S_CLEAR;
        clr_cnt_n = clr_addr + ADDR_W'(1);
      end
    end else if (state == S_BRUSH || (state == S_IDLE && touch_in && touch_new)) begin
      if (state == S_IDLE) begin
        src_x   = touch_x;
        src_y   = touch_y;
        src_c   = pen_color;
        cdx     = '0;
        cdy     = '0;
        bx_n    = touch_x;
        by_n    = touch_y;
        color_n = pen_color;
      end
      // Signed pixel position: off-screen pixels burn their cycle without writing.
      px     = int'(src_x) + int'(cdx) - R;
      py     = int'(src_y) + int'(cdy) - R;
      ena_n  = (px >= 0) && (px < DISPLAY_WIDTH) && (py >= 0) && (py < DISPLAY_HEIGHT);
      addr_n = ADDR_W'(py * DISPLAY_WIDTH + px);
      data_n = src_c;
      busy_n = 1'b1;
      if (cdx == B_LAST && cdy == B_LAST) begin
        state_n      = S_IDLE;
        dx_n         = '0;
        dy_n         = '0;
        last_x_n     = src_x;
        last_y_n     = src_y;
        last_valid_n = 1'b1;
      end else begin
        state_n = S_BRUSH;
        if (cdx == B_LAST) begin
          dx_n = '0;
          dy_n = cdy + 4'd1;
        end else begin
          dx_n = cdx + 4'd1;
          dy_n = cdy;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter on a reduced 40x24 screen with a 3x3 brush
// so that complete clear sweeps stay short.
module tb_vram_write_arbiter;
  localparam int W    = 40;
  localparam int H    = 24;
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX);

  logic          clk = 1'b0;
  logic          rst, clear_req, touch_valid;
  logic [8:0]    touch_x, touch_y;
  logic [15:0]   pen_color;
  logic          vram_wr_ena, busy, clearing;
  logic [AW-1:0] vram_wr_addr;
  logic [15:0]   vram_wr_data;

  int n_assert = 0;
  int n_fail   = 0;
  int wa[$];
  int wd[$];
  int busy_cnt, first_idx;
  int exp_a[$];

  vram_write_arbiter #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .BRUSH(3), .CLEAR_COLOR(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .touch_valid(touch_valid),
    .touch_x(touch_x), .touch_y(touch_y), .pen_color(pen_color),
    .vram_wr_ena(vram_wr_ena), .vram_wr_addr(vram_wr_addr), .vram_wr_data(vram_wr_data),
    .busy(busy), .clearing(clearing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Entered #1 after the edge on which address 0 of a sweep was registered.
  task automatic check_clear(input string tag);
    int bad_at;
    bad_at = -1;
    for (int i = 0; i < NPIX; i++) begin
      if (bad_at < 0 && !(vram_wr_ena === 1'b1 && int'(vram_wr_addr) == i &&
          vram_wr_data === 16'hFFFF && clearing === 1'b1 && busy === 1'b1))
        bad_at = i;
      if (i == 10) begin
        touch_valid = 1'b1; touch_x = 9'd5; touch_y = 9'd5; pen_color = 16'h0BAD;
        adv();
        touch_valid = 1'b0;
      end else begin
        adv();
      end
    end
    chk({tag, "_first_bad_index"}, bad_at, -1);
    chk({tag, "_done_ena"}, int'(vram_wr_ena), 0);
    chk({tag, "_done_busy"}, int'(busy), 0);
    chk({tag, "_done_clearing"}, int'(clearing), 0);
    adv();
    chk({tag, "_no_queued_touch"}, int'(busy), 0);
  endtask

  task automatic run_touch(input int x, input int y, input logic [15:0] c, input int ncyc);
    wa.delete(); wd.delete();
    busy_cnt = 0; first_idx = -1;
    @(negedge clk);
    touch_valid = 1'b1; touch_x = 9'(x); touch_y = 9'(y); pen_color = c;
    adv();
    touch_valid = 1'b0; pen_color = 16'h0000;
    for (int i = 0; i < ncyc; i++) begin
      if (vram_wr_ena === 1'b1) begin
        wa.push_back(int'(vram_wr_addr));
        wd.push_back(int'(vram_wr_data));
        if (first_idx < 0) first_idx = i;
      end
      if (busy === 1'b1) busy_cnt++;
      adv();
    end
  endtask

  task automatic check_writes(input string tag, input logic [15:0] c, input int nbusy);
    chk({tag, "_nwrites"}, wa.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wa.size(); i++) begin
      chk({tag, "_addr"}, wa[i], exp_a[i]);
      chk({tag, "_data"}, wd[i], int'(c));
    end
    chk({tag, "_busy_cycles"}, busy_cnt, nbusy);
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; clear_req = 1'b0; touch_valid = 1'b0;
    touch_x = '0; touch_y = '0; pen_color = '0;
    repeat (3) adv();
    chk("rst_ena", int'(vram_wr_ena), 0);
    chk("rst_addr", int'(vram_wr_addr), 0);
    chk("rst_data", int'(vram_wr_data), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_clearing", int'(clearing), 1);
    @(negedge clk); rst = 1'b0;
    adv();
    check_clear("init_clear");

    // Centre brush: rows 9..11, cols 19..21 at width 40
    exp_a = '{379, 380, 381, 419, 420, 421, 459, 460, 461};
    run_touch(20, 10, 16'hF800, 12);
    chk("centre_first_write_cycle", first_idx, 0);
    check_writes("centre", 16'hF800, 9);

    exp_a = '{};
    run_touch(20, 10, 16'h07E0, 6);
    check_writes("repeat_ignored", 16'h07E0, 0);

    exp_a = '{0, 1, 40, 41};
    run_touch(0, 0, 16'h001F, 12);
    check_writes("corner_tl", 16'h001F, 9);

    exp_a = '{38, 39, 78, 79};
    run_touch(39, 0, 16'h1234, 12);
    check_writes("corner_tr_nowrap", 16'h1234, 9);

    exp_a = '{918, 919, 958, 959};
    run_touch(39, 23, 16'h5A5A, 12);
    check_writes("corner_br", 16'h5A5A, 9);

    exp_a = '{};
    run_touch(40, 5, 16'hAAAA, 6);
    check_writes("oob_x", 16'hAAAA, 0);
    run_touch(5, 24, 16'hAAAA, 6);
    check_writes("oob_y", 16'hAAAA, 0);

    // Abort a brush after four of its cycles with clear_req
    exp_a = '{379, 380, 381, 419};
    run_touch(20, 10, 16'hF800, 3);
    if (vram_wr_ena === 1'b1) begin wa.push_back(int'(vram_wr_addr)); wd.push_back(int'(vram_wr_data)); end
    chk("abort_pre_nwrites", wa.size(), 4);
    for (int i = 0; i < 4 && i < wa.size(); i++) chk("abort_pre_addr", wa[i], exp_a[i]);
    @(negedge clk); clear_req = 1'b1;
    adv();
    clear_req = 1'b0;
    chk("abort_addr0", int'(vram_wr_addr), 0);
    chk("abort_data", int'(vram_wr_data), 16'hFFFF);
    chk("abort_clearing", int'(clearing), 1);
    // Let 50 writes go, then restart the sweep from 0 with another request
    repeat (50) adv();
    chk("mid_clear_addr", int'(vram_wr_addr), 50);
    @(negedge clk); clear_req = 1'b1;
    adv();
    clear_req = 1'b0;
    check_clear("restart_clear");

    // Last-brush memory was wiped by the clear, so this location is accepted again
    exp_a = '{918, 919, 958, 959};
    run_touch(39, 23, 16'hC0DE, 12);
    check_writes("after_clear_again", 16'hC0DE, 9);

    // Synchronous reset in the middle of a brush
    exp_a = '{};
    run_touch(10, 10, 16'h7777, 2);
    @(negedge clk); rst = 1'b1;
    adv();
    chk("midrst_ena", int'(vram_wr_ena), 0);
    chk("midrst_addr", int'(vram_wr_addr), 0);
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_clearing", int'(clearing), 1);
    @(negedge clk); rst = 1'b0;
    adv();
    check_clear("post_rst_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
